// File: rtl/fakeram130_1r1w_model.sv
// -----------------------------------------------------------------------------
// fakeram130_1r1w_model
//
// Behavioural 1-read/1-write fake SRAM used in simulation builds in place of
// the sky130hd blackbox macros. Beyond a plain 1R1W array it provides
// bit-masked writes, a 1..3 cycle read pipeline, a same-address read/write
// bypass selectable between new and old data, and a zero-fill sweep after
// reset.
//
// Ports
//   clk           in   1           clock, all state changes on rising edge
//   rst_n         in   1           asynchronous active-low reset
//   ready_out     out  1           1 = array accepts reads and writes
//   rd_ce_in      in   1           read enable
//   rd_addr_in    in   ADDR_WIDTH  read address
//   rd_out        out  BITS        read data, held between valid pulses
//   rd_valid_out  out  1           one-cycle pulse per accepted read
//   wr_ce_in      in   1           write enable
//   wr_addr_in    in   ADDR_WIDTH  write address
//   wd_in         in   BITS        write data
//   w_mask_in     in   BITS        per-bit write mask, 1 = bit written
// -----------------------------------------------------------------------------
module fakeram130_1r1w_model #(
  parameter int BITS         = 96,
  parameter int WORD_DEPTH   = 64,
  parameter int ADDR_WIDTH   = 6,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 1,
  parameter int INIT_ZERO    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready_out,
  input  logic                  rd_ce_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr_in,
  output logic [BITS-1:0]       rd_out,
  output logic                  rd_valid_out,
  input  logic                  wr_ce_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [BITS-1:0]       wd_in,
  input  logic [BITS-1:0]       w_mask_in
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Addresses are compared one bit wider so that WORD_DEPTH == 2**ADDR_WIDTH
  // is representable.
  localparam logic [ADDR_WIDTH:0] C_DEPTH     = (ADDR_WIDTH+1)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH:0] C_LAST      = (ADDR_WIDTH+1)'(WORD_DEPTH - 1);
  localparam state_t              C_RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_READY;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic [ADDR_WIDTH-1:0] w_init_cnt_next;
  logic                  w_init_we;
  logic                  r_ready;

  logic [BITS-1:0]       r_mem [WORD_DEPTH];

  logic                  w_rd_in_range;
  logic                  w_wr_in_range;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_bypass;
  logic [BITS-1:0]       w_wr_merged;
  logic [BITS-1:0]       w_rd_word;

  // ---------------------------------------------------------------------------
  // Init / ready FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_init_cnt_next = r_init_cnt;
    w_init_we       = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_we       = 1'b1;
        w_init_cnt_next = r_init_cnt + ADDR_WIDTH'(1);
        if ({1'b0, r_init_cnt} == C_LAST) begin
          w_state_next = ST_READY;
        end
      end
      ST_READY: begin
        w_state_next = ST_READY;
      end
      default: begin
        w_state_next = C_RST_STATE;
      end
    endcase
  end

  // ready is registered from the next state so that it rises on the same edge
  // that writes the last word of the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= C_RST_STATE;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_init_cnt <= w_init_cnt_next;
      r_ready    <= (w_state_next == ST_READY);
    end
  end

  assign ready_out = r_ready;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  assign w_rd_in_range = ({1'b0, rd_addr_in} < C_DEPTH);
  assign w_wr_in_range = ({1'b0, wr_addr_in} < C_DEPTH);
  assign w_rd_acc      = r_ready & rd_ce_in;
  assign w_wr_acc      = r_ready & wr_ce_in & w_wr_in_range;

  assign w_wr_merged   = (r_mem[wr_addr_in] & ~w_mask_in) | (wd_in & w_mask_in);

  // An in-range read address equal to the write address implies the write is
  // in range too, so the bypass only needs the address match.
  assign w_bypass      = (WRITE_FIRST != 0) && wr_ce_in && (wr_addr_in == rd_addr_in);

  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) begin
      w_rd_word = w_bypass ? w_wr_merged : r_mem[rd_addr_in];
    end
  end

  // ---------------------------------------------------------------------------
  // Array: only the sweep and accepted writes modify it; reset never does.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n && w_init_we) begin
      r_mem[r_init_cnt] <= '0;
    end else if (rst_n && w_wr_acc) begin
      r_mem[wr_addr_in] <= w_wr_merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline. The word is captured at the accepting edge, so later writes
  // cannot disturb data already in flight. Each stage only loads on a valid
  // beat, which makes the last stage hold its data between pulses.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
      logic            w_in_vld;
      logic [BITS-1:0] w_in_data;
      logic            r_vld;
      logic [BITS-1:0] r_data;

      if (gi == 0) begin : g_first
        assign w_in_vld  = w_rd_acc;
        assign w_in_data = w_rd_word;
      end else begin : g_next
        assign w_in_vld  = g_stage[gi-1].r_vld;
        assign w_in_data = g_stage[gi-1].r_data;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld  <= 1'b0;
          r_data <= '0;
        end else begin
          r_vld <= w_in_vld;
          if (w_in_vld) begin
            r_data <= w_in_data;
          end
        end
      end
    end
  endgenerate

  assign rd_valid_out = g_stage[READ_LATENCY-1].r_vld;
  assign rd_out       = g_stage[READ_LATENCY-1].r_data;

endmodule

// File: tb/tb_fakeram130_1r1w_model.sv
// -----------------------------------------------------------------------------
// tb_fakeram130_1r1w_model
//
// Two instances share one stimulus stream:
//   u0 : 64 words, read latency 1, write-first
//   u1 : 48 words, read latency 3, read-old (WRITE_FIRST = 0)
// A per-instance reference model (plain array plus a due-cycle schedule of
// expected read results) is stepped on every edge and compared after it.
// -----------------------------------------------------------------------------
module tb_fakeram130_1r1w_model;

  localparam int BITS = 96;
  localparam int AW   = 6;
  localparam int DEPTH [2] = '{64, 48};
  localparam int LAT   [2] = '{1, 3};
  localparam int WF    [2] = '{1, 0};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rd_ce = 1'b0;
  logic [AW-1:0]   rd_addr = '0;
  logic            wr_ce = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [BITS-1:0] wd = '0;
  logic [BITS-1:0] wmask = '0;

  logic            rdy_o [2];
  logic            vld_o [2];
  logic [BITS-1:0] rd_o  [2];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [BITS-1:0] mm     [2][64];
  int              edges  [2];
  bit              ring_v [2][8];
  logic [BITS-1:0] ring_d [2][8];
  logic [BITS-1:0] last   [2];
  int              g = 0;

  always #5 clk = ~clk;

  fakeram130_1r1w_model #(
    .BITS(BITS), .WORD_DEPTH(64), .ADDR_WIDTH(AW),
    .READ_LATENCY(1), .WRITE_FIRST(1), .INIT_ZERO(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .ready_out(rdy_o[0]),
    .rd_ce_in(rd_ce), .rd_addr_in(rd_addr), .rd_out(rd_o[0]), .rd_valid_out(vld_o[0]),
    .wr_ce_in(wr_ce), .wr_addr_in(wr_addr), .wd_in(wd), .w_mask_in(wmask)
  );

  fakeram130_1r1w_model #(
    .BITS(BITS), .WORD_DEPTH(48), .ADDR_WIDTH(AW),
    .READ_LATENCY(3), .WRITE_FIRST(0), .INIT_ZERO(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .ready_out(rdy_o[1]),
    .rd_ce_in(rd_ce), .rd_addr_in(rd_addr), .rd_out(rd_o[1]), .rd_valid_out(vld_o[1]),
    .wr_ce_in(wr_ce), .wr_addr_in(wr_addr), .wd_in(wd), .w_mask_in(wmask)
  );

  task automatic check_val(input string tag, input logic [BITS-1:0] got,
                           input logic [BITS-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // One model edge: acceptance uses the ready state held before the edge.
  task automatic model_edge();
    logic [BITS-1:0] merged;
    logic [BITS-1:0] rw;
    bit              rdy;
    int              slot;
    g++;
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        rdy = (edges[k] >= DEPTH[k]);
        merged = '0;
        if (int'(wr_addr) < DEPTH[k]) begin
          merged = (mm[k][wr_addr] & ~wmask) | (wd & wmask);
        end
        if (rdy && rd_ce) begin
          if (int'(rd_addr) >= DEPTH[k]) rw = '0;
          else if (WF[k] != 0 && wr_ce && wr_addr == rd_addr) rw = merged;
          else rw = mm[k][rd_addr];
          slot = (g + LAT[k] - 1) % 8;
          ring_v[k][slot] = 1'b1;
          ring_d[k][slot] = rw;
        end
        if (rdy && wr_ce && int'(wr_addr) < DEPTH[k]) mm[k][wr_addr] = merged;
        edges[k]++;
        if (edges[k] == DEPTH[k]) begin
          for (int i = 0; i < 64; i++) mm[k][i] = '0;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      edges[k] = 0;
      last[k]  = '0;
      for (int s = 0; s < 8; s++) ring_v[k][s] = 1'b0;
    end
  endtask

  task automatic compare();
    int  slot;
    bit  exp_rdy;
    slot = g % 8;
    for (int k = 0; k < 2; k++) begin
      exp_rdy = rst_n && (edges[k] >= DEPTH[k]);
      check_val($sformatf("u%0d_ready", k), BITS'(rdy_o[k]), BITS'(exp_rdy));
      check_val($sformatf("u%0d_valid", k), BITS'(vld_o[k]), BITS'(ring_v[k][slot]));
      if (ring_v[k][slot]) last[k] = ring_d[k][slot];
      check_val($sformatf("u%0d_rdata", k), rd_o[k], last[k]);
      ring_v[k][slot] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle();
    rd_ce = 1'b0;
    wr_ce = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare();
    repeat (hold) step();
    rst_n = 1'b1;
  endtask

  task automatic wr(input int a, input logic [BITS-1:0] d, input logic [BITS-1:0] m);
    wr_ce = 1'b1; wr_addr = AW'(a); wd = d; wmask = m;
  endtask

  task automatic rd(input int a);
    rd_ce = 1'b1; rd_addr = AW'(a);
  endtask

  initial begin
    logic [BITS-1:0] ones;
    ones = '1;
    idle();
    do_reset(3);

    // sweep: readiness tracked by the model every cycle
    repeat (64) step();
    check_val("u0_ready_after_sweep", BITS'(rdy_o[0]), BITS'(1));

    // read back every address after the sweep
    for (int a = 0; a < 64; a++) begin
      rd(a); step();
      check_val("u0_sweep_zero", rd_o[0], '0);
    end
    idle(); repeat (3) step();

    // masked writes to address 5
    wr(5, ones, 96'hFF); step(); idle();
    rd(5); step(); idle();
    check_val("u0_mask_ff", rd_o[0], 96'hFF);
    wr(5, '0, 96'h0F); step(); idle();
    rd(5); step(); idle();
    check_val("u0_mask_0f", rd_o[0], 96'hF0);
    repeat (3) step();

    // consecutive reads through the 3-stage pipeline
    rd(1); step(); rd(2); step(); rd(3); step(); idle();
    repeat (4) step();

    // same-cycle read and write to address 7
    wr(7, 96'h11, ones); step(); idle();
    wr(7, 96'h22, ones); rd(7); step(); idle();
    check_val("u0_write_first", rd_o[0], 96'h22);
    step(); step();
    check_val("u1_read_old_vld", BITS'(vld_o[1]), BITS'(1));
    check_val("u1_read_old", rd_o[1], 96'h11);

    // address 50 exists in u0 but not in u1
    wr(50, ones, ones); step(); idle();
    rd(50); step(); idle();
    check_val("u0_addr50", rd_o[0], ones);
    step(); step();
    check_val("u1_addr50_zero", rd_o[1], '0);
    step();

    // reset with reads in flight, reads requested during the new sweep
    rd(1); step(); rd(2); step();
    do_reset(2);
    for (int i = 0; i < 70; i++) begin
      rd_ce = 1'(($urandom_range(0, 1)));
      rd_addr = AW'($urandom_range(0, 63));
      wr_ce = 1'(($urandom_range(0, 1)));
      wr_addr = AW'($urandom_range(0, 63));
      wd = {$urandom, $urandom, $urandom};
      wmask = ones;
      step();
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rd_ce   = 1'($urandom_range(0, 3) != 0);
      rd_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63))
                                            : AW'($urandom_range(0, 15));
      wr_ce   = 1'($urandom_range(0, 1));
      wr_addr = ($urandom_range(0, 3) == 0) ? rd_addr : AW'($urandom_range(0, 15));
      wd      = {$urandom, $urandom, $urandom};
      wmask   = ($urandom_range(0, 3) == 0) ? ones : {$urandom, $urandom, $urandom};
      step();
    end
    idle();
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
